// File: rtl/picomips_seq_mult.sv
// picoMIPS execute-stage sequential multiplier (shift-add, one partial
// product per cycle). Operands come from the register-file read ports; the
// selected product slice and its destination address go back to the
// register-file write port with a one-cycle write strobe.
//
// Build option: define SIGNED_MULT_EN to treat a/b as two's complement
// (magnitude multiply with a sign fix-up at completion). Without it the
// operands are unsigned and no sign logic exists.
//
// state | meaning
// IDLE  | waiting for start; operands and destination latched on accept
// RUN   | n shift-add iterations, busy=1, core stalled
// DONE  | single cycle, done=1, wr_en=1 unless destination is r0

module picomips_seq_mult #(
   parameter int n         = 8,
   parameter int OUT_SHIFT = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic [4:0]   dest_in,
   output logic         busy,
   output logic         done,
   output logic         wr_en,
   output logic [4:0]   dest_out,
   output logic [n-1:0] result
);

   localparam int CW = (n > 2) ? $clog2(n) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [2*n-1:0]   acc;
   logic [2*n-1:0]   mcand;
   logic [n-1:0]     mplier;
   logic [CW-1:0]    count;
   logic [4:0]       dest_lat;

   logic [n-1:0]     mag_a;
   logic [n-1:0]     mag_b;
   logic [2*n-1:0]   addend;
   logic [2*n-1:0]   acc_next;
   logic [2*n-1:0]   product;

`ifdef SIGNED_MULT_EN
   logic             sign;

   // Magnitudes of the two's complement operands; -2^(n-1) maps to 2^(n-1),
   // which still fits in n unsigned bits.
   always_comb begin
      mag_a = a[n-1] ? -a : a;
      mag_b = b[n-1] ? -b : b;
   end
`else
   // Unsigned operands pass straight through.
   always_comb begin
      mag_a = a;
      mag_b = b;
   end
`endif

   // Next accumulator value, and the final product including the last
   // partial product so the result can be captured on the DONE entry edge.
   always_comb begin
      addend   = mplier[0] ? mcand : '0;
      acc_next = acc + addend;
`ifdef SIGNED_MULT_EN
      product  = sign ? -acc_next : acc_next;
`else
      product  = acc_next;
`endif
   end

   // Controller FSM with datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         count    <= '0;
         dest_lat <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_en    <= 1'b0;
         dest_out <= '0;
         result   <= '0;
`ifdef SIGNED_MULT_EN
         sign     <= 1'b0;
`endif
      end else begin
         done  <= 1'b0;
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc      <= '0;
                  mcand    <= {{n{1'b0}}, mag_a};
                  mplier   <= mag_b;
                  dest_lat <= dest_in;
                  count    <= CW'(n - 1);
                  busy     <= 1'b1;
                  state    <= RUN;
`ifdef SIGNED_MULT_EN
                  sign     <= a[n-1] ^ b[n-1];
`endif
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - 1'b1;
               if (count == '0) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  // r0 is hardwired; never strobe a write to it.
                  wr_en    <= (dest_lat != 5'd0);
                  dest_out <= dest_lat;
                  result   <= product[OUT_SHIFT +: n];
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_picomips_seq_mult.sv
// Directed bench for picomips_seq_mult: two instances (OUT_SHIFT=0 and 8)
// share the same stimulus; expected values are hand-computed constants.

module tb_picomips_seq_mult;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [4:0] dest_in;

   logic       busy0, done0, wr_en0;
   logic [4:0] dest_out0;
   logic [7:0] result0;
   logic       busy8, done8, wr_en8;
   logic [4:0] dest_out8;
   logic [7:0] result8;

   int checks;
   int failures;

   picomips_seq_mult #(.n(8), .OUT_SHIFT(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .dest_in(dest_in),
      .busy(busy0), .done(done0), .wr_en(wr_en0), .dest_out(dest_out0), .result(result0)
   );

   picomips_seq_mult #(.n(8), .OUT_SHIFT(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .dest_in(dest_in),
      .busy(busy8), .done(done8), .wr_en(wr_en8), .dest_out(dest_out8), .result(result8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One operation with a single-cycle start pulse. Returns the number of
   // busy cycles, the cycle index (1 = first cycle after the start edge) in
   // which done was seen (0 = never), and how many wr_en cycles were seen.
   // Returns sampling the DONE cycle, so outputs are readable right away.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [4:0] td,
                         output int busy_n, output int done_at, output int wr_n);
      @(negedge clk);
      a = ta; b = tb_v; dest_in = td; start = 1'b1;
      @(posedge clk);
      busy_n = 0; done_at = 0; wr_n = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (busy0) busy_n++;
         if (wr_en0) wr_n++;
         if (done0) begin
            done_at = c;
            break;
         end
      end
   endtask

   int bn, da, wn, dn;

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; dest_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",   busy0,     1'b0);
      chk("rst_done",   done0,     1'b0);
      chk("rst_wr",     wr_en0,    1'b0);
      chk("rst_result", result0,   8'h00);
      chk("rst_dest",   dest_out0, 5'd0);
      reset = 1'b0;
      @(negedge clk);

      // 7 * 9 = 63
      run_op(8'd7, 8'd9, 5'd5, bn, da, wn);
      chk("t1_busy_cycles", bn, 8);
      chk("t1_done_cycle",  da, 9);
      chk("t1_wr",          wr_en0, 1'b1);
      chk("t1_result",      result0, 8'h3F);
      chk("t1_dest",        dest_out0, 5'd5);
      chk("t1_result_sh8",  result8, 8'h00);
      @(negedge clk);
      chk("t1_done_pulse",  done0, 1'b0);
      chk("t1_idle_busy",   busy0, 1'b0);

      // 255 * 255 = 0xFE01 unsigned; (-1)*(-1) = 1 signed
      run_op(8'hFF, 8'hFF, 5'd9, bn, da, wn);
      chk("t2_done_cycle",  da, 9);
      chk("t2_result_sh0",  result0, 8'h01);
`ifdef SIGNED_MULT_EN
      chk("t2_result_sh8",  result8, 8'h00);
`else
      chk("t2_result_sh8",  result8, 8'hFE);
`endif
      chk("t2_dest_sh8",    dest_out8, 5'd9);

`ifdef SIGNED_MULT_EN
      // -3 * 5 = -15 -> 0xFFF1
      run_op(8'hFD, 8'h05, 5'd2, bn, da, wn);
      chk("t3_done_cycle",  da, 9);
      chk("t3_neg_result",  result0, 8'hF1);
      chk("t3_neg_sh8",     result8, 8'hFF);
      // -128 * -128 = 0x4000
      run_op(8'h80, 8'h80, 5'd2, bn, da, wn);
      chk("t3_min_sh8",     result8, 8'h40);
      chk("t3_min_sh0",     result0, 8'h00);
`endif

      // Zero operand still takes the full latency.
      run_op(8'h00, 8'h55, 5'd3, bn, da, wn);
      chk("zero_busy_cycles", bn, 8);
      chk("zero_done_cycle",  da, 9);
      chk("zero_result",      result0, 8'h00);

      // Start held high; operands change mid-RUN.
      @(negedge clk);
      a = 8'd10; b = 8'd11; dest_in = 5'd4; start = 1'b1;
      @(posedge clk);
      dn = 0; da = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 3) begin a = 8'd200; b = 8'd200; dest_in = 5'd6; end
         if (done0) begin
            dn++;
            if (da == 0) da = c;
            chk("t4_first_result", result0, 8'h6E);
            chk("t4_first_dest",   dest_out0, 5'd4);
         end
      end
      chk("t4_done_count",  dn, 1);
      chk("t4_done_cycle",  da, 9);
      chk("t4_idle_gap",    busy0, 1'b0);
      @(negedge clk);
      chk("t4_reaccept",    busy0, 1'b1);
      start = 1'b0;
      da = 0;
      for (int c = 1; c <= 20; c++) begin
         if (done0) begin da = c; break; end
         @(negedge clk);
      end
      chk("t4_second_seen",  (da != 0), 1'b1);
      // 200*200 = 40000 = 0x9C40 (signed: 3136 = 0x0C40)
      chk("t4_second_result", result0, 8'h40);
      chk("t4_second_dest",   dest_out0, 5'd6);

      // Reset during RUN cycle 4.
      @(negedge clk);
      a = 8'd15; b = 8'd15; dest_in = 5'd8; start = 1'b1;
      @(posedge clk);
      dn = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      chk("t5_busy_before", busy0, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_busy",   busy0,   1'b0);
      chk("t5_result", result0, 8'h00);
      chk("t5_done",   done0,   1'b0);
      chk("t5_wr",     wr_en0,  1'b0);
      reset = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done0 || wr_en0) dn++;
      end
      chk("t5_no_late_done", dn, 0);
      run_op(8'd12, 8'd13, 5'd7, bn, da, wn);
      chk("t5_after_done_cycle", da, 9);
      chk("t5_after_result",     result0, 8'h9C);
      chk("t5_after_wr",         wr_en0, 1'b1);

      // Destination r0: completes but never writes.
      run_op(8'd3, 8'd4, 5'd0, bn, da, wn);
      chk("t6_done_cycle", da, 9);
      chk("t6_result",     result0, 8'h0C);
      chk("t6_wr_count",   wn, 0);
      chk("t6_dest",       dest_out0, 5'd0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
